// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and enable.
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic [1:0]  pc_source,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_zero,
    output logic [3:0]  alu_ctrl,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instr_count
);

    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StMemAdr = 4'd2;
    localparam logic [3:0] StMemRd  = 4'd3;
    localparam logic [3:0] StMemWb  = 4'd4;
    localparam logic [3:0] StMemWr  = 4'd5;
    localparam logic [3:0] StRex    = 4'd6;
    localparam logic [3:0] StRwb    = 4'd7;
    localparam logic [3:0] StBranch = 4'd8;
    localparam logic [3:0] StJump   = 4'd9;
    localparam logic [3:0] StIex    = 4'd10;
    localparam logic [3:0] StIwb    = 4'd11;
    localparam logic [3:0] StHalt   = 4'd12;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;

    // Where an illegal instruction leaves the FSM.
    localparam logic [3:0] StAbort = HALT_ON_ILLEGAL ? StHalt : StFetch;

    logic [3:0]  state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] count_q, count_d;
    logic        funct_legal;
    logic [3:0]  funct_alu;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = AluAdd;
        case (funct)
            FnAdd:   funct_alu = AluAdd;
            FnSub:   funct_alu = AluSub;
            FnAnd:   funct_alu = AluAnd;
            FnOr:    funct_alu = AluOr;
            FnSlt:   funct_alu = AluSlt;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        count_d   = instr_done ? count_q + 32'd1 : count_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw:   state_d = StMemAdr;
                    OpRtype:      state_d = StRex;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    OpAddi, OpAndi: state_d = StIex;
                    default: begin
                        state_d   = StAbort;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StRex: begin
                if (funct_legal) begin
                    state_d = StRwb;
                end else begin
                    state_d   = StAbort;
                    illegal_d = 1'b1;
                end
            end
            StIex:    state_d = StIwb;
            StMemWb, StMemWr, StRwb, StBranch, StJump, StIwb: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        pc_source  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        alu_ctrl   = AluAdd;
        instr_done = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_en     = 1'b1;
                alu_src_b = 2'b01;
            end
            StDecode: alu_src_b = 2'b11;
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
            end
            StRex: begin
                alu_src_a = 1'b1;
                alu_ctrl  = funct_alu;
            end
            StRwb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = AluSub;
                pc_source  = 2'b01;
                pc_en      = (opcode == OpBeq) ? zero : ~zero;
                instr_done = 1'b1;
            end
            StJump: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            StIex: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OpAndi) begin
                    alu_ctrl = AluAnd;
                    ext_zero = 1'b1;
                end
            end
            StIwb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons any instruction in flight without side effects.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (halt / skip on illegal) checked every cycle
// against per-instruction state sequences derived from the instruction class.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;

    always #5 clk = ~clk;

    logic        pc_en[2], iord[2], mem_read[2], mem_write[2], ir_write[2], reg_dst[2];
    logic        mem_to_reg[2], reg_write[2], alu_src_a[2], ext_zero[2], instr_done[2];
    logic        illegal[2];
    logic [1:0]  pc_source[2], alu_src_b[2];
    logic [3:0]  alu_ctrl[2], state[2];
    logic [31:0] instr_count[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_ctrl #(.HALT_ON_ILLEGAL(g == 0)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .opcode     (opcode),
            .funct      (funct),
            .zero       (zero),
            .pc_en      (pc_en[g]),
            .pc_source  (pc_source[g]),
            .iord       (iord[g]),
            .mem_read   (mem_read[g]),
            .mem_write  (mem_write[g]),
            .ir_write   (ir_write[g]),
            .reg_dst    (reg_dst[g]),
            .mem_to_reg (mem_to_reg[g]),
            .reg_write  (reg_write[g]),
            .alu_src_a  (alu_src_a[g]),
            .alu_src_b  (alu_src_b[g]),
            .ext_zero   (ext_zero[g]),
            .alu_ctrl   (alu_ctrl[g]),
            .state      (state[g]),
            .instr_done (instr_done[g]),
            .illegal    (illegal[g]),
            .instr_count(instr_count[g])
        );
    end

    int checks = 0;
    int failures = 0;
    int zmode = -1;

    // Reference model: position within the current instruction's state list.
    logic [5:0]  op_m[2], fn_m[2];
    int          pos[2];
    bit          halted[2], ill_m[2];
    logic [31:0] cnt_m[2];

    function automatic bit fn_ok(logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic int seq_len(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b100011:            return 5;
            6'b101011:            return 4;
            6'b000000:            return fn_ok(fn) ? 4 : 3;
            6'b000100, 6'b000101, 6'b000010: return 3;
            6'b001000, 6'b001100: return 4;
            default:              return 2;
        endcase
    endfunction

    function automatic bit is_illegal(logic [5:0] op, logic [5:0] fn);
        return seq_len(op, fn) == 2 || (op == 6'b000000 && !fn_ok(fn));
    endfunction

    function automatic int seq_state(logic [5:0] op, int idx);
        int s[5];
        s[0] = 0; s[1] = 1; s[2] = 0; s[3] = 0; s[4] = 0;
        case (op)
            6'b100011: begin s[2] = 2; s[3] = 3; s[4] = 4; end
            6'b101011: begin s[2] = 2; s[3] = 5; end
            6'b000000: begin s[2] = 6; s[3] = 7; end
            6'b000100, 6'b000101: s[2] = 8;
            6'b000010: s[2] = 9;
            6'b001000, 6'b001100: begin s[2] = 10; s[3] = 11; end
            default: ;
        endcase
        return s[idx];
    endfunction

    function automatic logic [23:0] exp_vec(int st, logic [5:0] op, logic [5:0] fn, logic z,
                                            logic ill, logic rst);
        logic pe, io, mr, mw, irw, rd, m2r, rw, sa, ez, dn;
        logic [1:0] ps, sb;
        logic [3:0] alu;
        {pe, io, mr, mw, irw, rd, m2r, rw, sa, ez, dn} = '0;
        ps = 2'b00; sb = 2'b00; alu = 4'b0010;
        case (st)
            0:  begin mr = 1; irw = 1; pe = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; dn = 1; end
            5:  begin mw = 1; io = 1; dn = 1; end
            6:  begin
                sa = 1;
                case (fn)
                    6'b100010: alu = 4'b0110;
                    6'b100100: alu = 4'b0000;
                    6'b100101: alu = 4'b0001;
                    6'b101010: alu = 4'b0111;
                    default:   alu = 4'b0010;
                endcase
            end
            7:  begin rw = 1; rd = 1; dn = 1; end
            8:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pe = (op == 6'b000100) ? z : !z;
                      dn = 1; end
            9:  begin ps = 2'b10; pe = 1; dn = 1; end
            10: begin sa = 1; sb = 2'b10;
                      if (op == 6'b001100) begin alu = 4'b0000; ez = 1; end end
            11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        if (rst) {pe, irw, mr, mw, rw} = '0;
        return {4'(st), pe, ps, io, mr, mw, irw, rd, m2r, rw, sa, sb, ez, alu, dn, ill};
    endfunction

    function automatic logic [23:0] obs_vec(int d);
        return {state[d], pc_en[d], pc_source[d], iord[d], mem_read[d], mem_write[d],
                ir_write[d], reg_dst[d], mem_to_reg[d], reg_write[d], alu_src_a[d],
                alu_src_b[d], ext_zero[d], alu_ctrl[d], instr_done[d], illegal[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0; halted[d] = 0; ill_m[d] = 0; cnt_m[d] = 0;
            op_m[d] = '0; fn_m[d] = '0;
        end
    endtask

    task automatic cycle();
        int st[2];
        logic [23:0] e;
        zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
        for (int d = 0; d < 2; d++) begin
            if (pos[d] == 0 && !halted[d]) begin
                op_m[d] = opcode;
                fn_m[d] = funct;
            end
            st[d] = halted[d] ? 12 : seq_state(op_m[d], pos[d]);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            e = exp_vec(st[d], op_m[d], fn_m[d], zero, ill_m[d], reset);
            checks++;
            assert (obs_vec(d) === e) else begin
                failures++;
                $error("FAIL outputs dut=%0d st=%0d obs=%h exp=%h", d, st[d], obs_vec(d), e);
            end
            checks++;
            assert (instr_count[d] === cnt_m[d]) else begin
                failures++;
                $error("FAIL instr_count dut=%0d obs=%0d exp=%0d", d, instr_count[d], cnt_m[d]);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                pos[d] = 0; halted[d] = 0; ill_m[d] = 0; cnt_m[d] = 0;
            end else if (!halted[d]) begin
                if (st[d] inside {4, 5, 7, 8, 9, 11}) cnt_m[d] = cnt_m[d] + 32'd1;
                if (pos[d] == seq_len(op_m[d], fn_m[d]) - 1) begin
                    if (is_illegal(op_m[d], fn_m[d])) begin
                        ill_m[d] = 1;
                        halted[d] = (d == 0);
                    end
                    pos[d] = 0;
                end else begin
                    pos[d]++;
                end
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        repeat (seq_len(op, fn)) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    logic [5:0] rnd_op[12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                               6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b001000, 6'b001100};
    logic [5:0] rnd_fn[12] = '{6'h00, 6'h00, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b101010, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        do_reset();

        run_instr(6'b100011, 6'h00);             // lw
        run_instr(6'b000000, 6'b100000);         // add
        run_instr(6'b000000, 6'b100010);         // sub
        zmode = 1; run_instr(6'b000100, 6'h00);  // beq taken
        zmode = 0; run_instr(6'b000100, 6'h00);  // beq not taken
        zmode = 0; run_instr(6'b000101, 6'h00);  // bne taken
        zmode = 1; run_instr(6'b000101, 6'h00);  // bne not taken
        zmode = -1;
        run_instr(6'b001100, 6'h15);             // andi
        run_instr(6'b001000, 6'h2A);             // addi
        run_instr(6'b101011, 6'h00);             // sw
        run_instr(6'b000010, 6'h00);             // j

        for (int i = 0; i < 200; i++) begin
            int k;
            k = $urandom_range(0, 11);
            run_instr(rnd_op[k], (k >= 2 && k <= 6) ? rnd_fn[k] : 6'($urandom));
        end

        // Illegal opcode: halt instance parks, skip instance resumes with jumps.
        opcode = 6'b111111; funct = 6'($urandom);
        repeat (2) cycle();
        opcode = 6'b000010;
        repeat (10) cycle();
        do_reset();

        // Illegal funct under an R-type opcode.
        opcode = 6'b000000; funct = 6'b000000;
        repeat (3) cycle();
        opcode = 6'b001000;
        repeat (5) cycle();
        do_reset();

        // Reset during MEMRD of a lw, then a clean sw.
        run_instr(6'b000000, 6'b101010);
        opcode = 6'b100011;
        repeat (3) cycle();
        do_reset();
        run_instr(6'b101011, 6'h00);
        run_instr(6'b000000, 6'b100101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
